// File: rtl/conv_seq_ctrl.sv
// Per-channel sequencer for the shared add/sub unit: walks the power-of-two
// coefficient groups for one sample and accumulates a 40-bit y.
module conv_seq_ctrl #(
    parameter int NUM_R   = 16,
    parameter int COEF_AW = 9,
    parameter int DATA_AW = 8,
    parameter int ACC_W   = 40,
    localparam int J_W    = $clog2(NUM_R)
) (
    input  logic               Sclk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DATA_AW-1:0] cur_idx,
    input  logic [DATA_AW:0]   samp_cnt,
    output logic [J_W-1:0]     rj_addr,
    input  logic [7:0]         rj_data,
    output logic [COEF_AW-1:0] coef_addr,
    input  logic [8:0]         coef_data,
    output logic [DATA_AW-1:0] x_addr,
    input  logic [15:0]        x_data,
    output logic [ACC_W-1:0]   add_a,
    output logic [ACC_W-1:0]   add_b,
    output logic               addsub,
    output logic               adder_en,
    input  logic [ACC_W-1:0]   sum,
    output logic               busy,
    output logic [ACC_W-1:0]   y_out,
    output logic               y_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_RJ_RD, S_RJ_WAIT, S_C_RD, S_X_RD, S_ACC, S_SHIFT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   y_out_q, y_out_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [J_W-1:0]     rj_addr_q, rj_addr_d;
    logic [COEF_AW-1:0] coef_addr_q, coef_addr_d;
    logic [DATA_AW-1:0] x_addr_q, x_addr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               y_valid_q, y_valid_d;
    logic [DATA_AW-1:0] x_rd_addr;

    // The history address is presented during X_RD so x_data lands in ACC.
    assign x_rd_addr = cur_idx - DATA_AW'(coef_data[7:0]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        y_out_d     = y_out_q;
        j_d         = j_q;
        rj_addr_d   = rj_addr_q;
        coef_addr_d = coef_addr_q;
        x_addr_d    = x_addr_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        y_valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    j_d         = '0;
                    rj_addr_d   = '0;
                    coef_addr_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_RJ_RD;
                end
            end
            S_RJ_RD: state_d = S_RJ_WAIT;
            S_RJ_WAIT: begin
                cnt_d   = rj_data;
                state_d = (rj_data == 8'd0) ? S_SHIFT : S_C_RD;
            end
            S_C_RD: state_d = S_X_RD;
            S_X_RD: begin
                sign_d   = coef_data[8];
                mask_d   = ((DATA_AW+1)'(coef_data[7:0]) >= samp_cnt);
                x_addr_d = x_rd_addr;
                state_d  = S_ACC;
            end
            S_ACC: begin
                if (!mask_q) acc_d = sum;
                coef_addr_d = coef_addr_q + 1'b1;
                cnt_d       = cnt_q - 8'd1;
                state_d     = (cnt_q == 8'd1) ? S_SHIFT : S_C_RD;
            end
            S_SHIFT: begin
                acc_d = $signed(acc_q) >>> 1;
                if (j_q == J_W'(NUM_R - 1)) begin
                    y_out_d   = acc_d;
                    y_valid_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    j_d       = j_q + 1'b1;
                    rj_addr_d = j_q + 1'b1;
                    state_d   = S_RJ_RD;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            y_valid_d = 1'b0;
            y_out_d   = y_out_q;
        end
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            y_out_q     <= '0;
            j_q         <= '0;
            rj_addr_q   <= '0;
            coef_addr_q <= '0;
            x_addr_q    <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            mask_q      <= 1'b0;
            busy_q      <= 1'b0;
            y_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            y_out_q     <= y_out_d;
            j_q         <= j_d;
            rj_addr_q   <= rj_addr_d;
            coef_addr_q <= coef_addr_d;
            x_addr_q    <= x_addr_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            y_valid_q   <= y_valid_d;
        end
    end

    assign rj_addr   = rj_addr_q;
    assign coef_addr = coef_addr_q;
    assign x_addr    = (state_q == S_X_RD) ? x_rd_addr : x_addr_q;
    assign adder_en  = (state_q == S_ACC) && !mask_q;
    assign addsub    = (state_q == S_ACC) && sign_q;
    assign add_a     = adder_en ? {{(ACC_W-32){x_data[15]}}, x_data, 16'h0000} : '0;
    assign add_b     = acc_q;
    assign busy      = busy_q;
    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;

endmodule
